// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid bit plus its WIDTH-bit payload.
// Loads from the previous slot when the ready chain allows it, otherwise holds.
module pipe_stage #(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             armed,
    input  logic             flush,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_q,
    output logic [WIDTH-1:0] d_q
);

    logic             v_d;
    logic [WIDTH-1:0] d_d;

    // NOTE: defaults first, so every path assigns v_d/d_d and no latch is inferred.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (!armed) begin
            v_d = 1'b0;
            d_d = '0;
        end else if (flush) begin
            v_d = 1'b0;
            if (CLEAR_DATA) d_d = '0;
        end else if (load) begin
            v_d = v_in;
            // A bubble keeps the old payload unless invalid slots are scrubbed.
            if (v_in)            d_d = d_in;
            else if (CLEAR_DATA) d_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments; the payload is reset too, so
    // nothing from before a reset can leak out of the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register of DEPTH slots with valid/ready on both sides, flush,
// bubble collapsing through a combinational ready chain, and power-on arming.
module pipe_reg_chain #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 1,
    parameter  bit CLEAR_DATA = 1'b1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic             rst_act;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_src;
    logic [WIDTH-1:0] d_q   [DEPTH];
    logic [WIDTH-1:0] d_src [DEPTH];
    logic             accept, xfer;

    // An unknown reset level is treated as asserted; in hardware this is just rst.
    assign rst_act = (rst !== 1'b0);

    // Ready ripples from the output back to the input so a bubble is absorbed at once.
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v_q[i] | rdy[i+1];
        end
    end

    always_comb begin
        v_src[0] = in_valid;
        d_src[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            v_src[i] = v_q[i-1];
            d_src[i] = d_q[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk   (clk),
            .rst   (rst_act),
            .armed (armed_q),
            .flush (flush),
            .load  (rdy[g]),
            .v_in  (v_src[g]),
            .d_in  (d_src[g]),
            .v_q   (v_q[g]),
            .d_q   (d_q[g])
        );
    end

    assign in_ready  = armed_q & !flush & rdy[0];
    assign out_valid = armed_q & v_q[DEPTH-1];
    assign out_data  = armed_q ? d_q[DEPTH-1] : '0;
    assign occupancy = armed_q ? occ_q : '0;

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    always_comb begin
        armed_d = armed_q;
        occ_d   = occ_q;
        if (!armed_q || flush) begin
            occ_d = '0;
        end else if (accept && !xfer) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (xfer && !accept) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    // armed has no clear: only power-up leaves it low, and any reset sets it.
    always_ff @(posedge clk or posedge rst_act) begin
        if (rst_act) begin
            armed_q <= 1'b1;
            occ_q   <= '0;
        end else begin
            armed_q <= armed_d;
            occ_q   <= occ_d;
        end
    end

endmodule
